toggle_decoder: RTL and testbench

- Receive-side block for a toggle-encoded serial line driven by a T flip-flop.
- The transmitter encodes each bit as toggle (1) or hold (0) of the flip-flop output q; this block samples q, recovers t = q XOR previous q, frames words and hands them downstream with a valid/ready handshake.
- Sits directly after the T-FF (same clk domain); provides error flags and a toggle counter for lab observation.

---
 rtl/toggle_decoder.sv | 141 ++++++++++++++
 tb/tb_toggle_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_decoder.sv
// Receive side of a toggle-encoded serial line: recovers t = q ^ q_prev, frames
// start/WIDTH data/stop, and hands words downstream over a valid/ready handshake.
module toggle_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_in,
  output logic             t_rec,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {PRIME, IDLE, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic               q_prev_q, q_prev_d;
  logic               t_rec_q, t_rec_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic t_now;
  logic deliver;
  logic ferr_set;
  logic ovr_set;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    ovr_set   = 1'b0;

    t_now    = q_in ^ q_prev_q;
    q_prev_d = q_in;
    t_rec_d  = (state_q == PRIME) ? 1'b0 : t_now;

    if (state_q != PRIME && t_now) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      PRIME: state_d = IDLE;
      IDLE: begin
        if (t_now) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        shift_d[bit_idx_q] = t_now;
        if (bit_idx_q == LAST_IDX) begin
          state_d = STOP;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        // A toggle in the stop slot ends the frame; it is never reused as a start.
        state_d = IDLE;
        if (t_now) begin
          ferr_set = 1'b1;
        end else begin
          deliver = 1'b1;
        end
      end
      default: state_d = PRIME;
    endcase

    if (deliver) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_set = valid_q && !data_ready;
    end

    if (err_clr) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (ferr_set) ferr_d = 1'b1;
    if (ovr_set)  ovr_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PRIME;
      q_prev_q  <= 1'b0;
      t_rec_q   <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      q_prev_q  <= q_prev_d;
      t_rec_q   <= t_rec_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign t_rec      = t_rec_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// Bench for toggle_decoder: line driven bit-by-bit as toggles, expected words queued
// per frame and popped by a handshake monitor; a CNT_W=4 copy covers counter wrap.
module tb_toggle_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         q_in;
  logic         data_ready;
  logic         err_clr;

  logic         t_rec_a, t_rec_b;
  logic [W-1:0] data_out_a, data_out_b;
  logic         data_valid_a, data_valid_b;
  logic         frame_err_a, frame_err_b;
  logic         overrun_a, overrun_b;
  logic [15:0]  cnt_a;
  logic [3:0]   cnt_b;

  toggle_decoder #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .t_rec(t_rec_a),
    .data_out(data_out_a), .data_valid(data_valid_a), .data_ready(data_ready),
    .frame_err(frame_err_a), .overrun(overrun_a), .err_clr(err_clr),
    .toggle_cnt(cnt_a)
  );

  toggle_decoder #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .t_rec(t_rec_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .data_ready(data_ready),
    .frame_err(frame_err_b), .overrun(overrun_b), .err_clr(err_clr),
    .toggle_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  int unsigned  m_cnt;
  bit           primed;
  bit           m_ferr;
  bit           m_ovr;
  int           rdy_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted handshake must match the oldest expected word.
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && data_valid_a && data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h required none", data_out_a);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("data_out", 32'(data_out_a), 32'(mon_exp));
      end
    end
  end

  // One line cycle: drive a toggle/hold, wait past the edge, check recovered bit and counters.
  task automatic step(input bit t, input bit clr = 1'b0, input int rdy = -1);
    q_in    = q_in ^ t;
    err_clr = clr;
    if (rdy >= 0)          data_ready = rdy[0];
    else if (rdy_mode == 2) data_ready = 1'($urandom_range(0, 1));
    else                   data_ready = rdy_mode[0];
    @(posedge clk);
    #1;
    if (primed && t) m_cnt++;
    chk("t_rec", 32'(t_rec_a), 32'(primed ? t : 1'b0));
    chk("toggle_cnt", 32'(cnt_a), m_cnt % 65536);
    chk("toggle_cnt4", 32'(cnt_b), m_cnt % 16);
    primed  = 1'b1;
    err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit push, input bit stop_t,
                            input bit clr = 1'b0, input int stop_rdy = -1);
    if (push) exp_q.push_back(w);
    step(1'b1);
    for (int i = 0; i < W; i++) step(w[i]);
    step(stop_t, clr, stop_rdy);
    if (clr) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (stop_t) m_ferr = 1'b1;
  endtask

  task automatic chk_flags();
    chk("frame_err", 32'(frame_err_a), 32'(m_ferr));
    chk("overrun", 32'(overrun_a), 32'(m_ovr));
    chk("frame_err4", 32'(frame_err_b), 32'(m_ferr));
    chk("overrun4", 32'(overrun_b), 32'(m_ovr));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data_out", 32'(data_out_a), 32'(0));
    chk("rst_data_valid", 32'(data_valid_a), 32'(0));
    chk("rst_t_rec", 32'(t_rec_a), 32'(0));
    chk("rst_cnt", 32'(cnt_a), 32'(0));
    chk("rst_frame_err", 32'(frame_err_a), 32'(0));
    chk("rst_overrun", 32'(overrun_a), 32'(0));
    chk("rst_data_out4", 32'(data_out_b), 32'(0));
    chk("rst_t_rec4", 32'(t_rec_b), 32'(0));
  endtask

  // Called at posedge+1; outputs must clear while rst_n is still low.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    primed = 1'b0;
    m_cnt  = 0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    bit           e;
    bit           c;
    int           n;

    rst_n = 1'b0; q_in = 1'b1; data_ready = 1'b0; err_clr = 1'b0;
    rdy_mode = 1; m_cnt = 0; primed = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // q_in held high across reset release: PRIME must absorb it, no toggle seen.
    repeat (10) step(1'b0);
    chk("idle_valid", 32'(data_valid_a), 32'(0));
    chk_flags();

    rdy_mode = 1;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_valid", 32'(data_valid_a), 32'(1));
    chk("a5_data", 32'(data_out_a), 32'(8'hA5));
    chk("a5_cnt", 32'(cnt_a), 32'(5));
    step(1'b0);
    chk("a5_valid_drop", 32'(data_valid_a), 32'(0));

    rdy_mode = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    m_ovr = 1'b1;
    chk("ovr_valid", 32'(data_valid_a), 32'(1));
    chk("ovr_data", 32'(data_out_a), 32'(8'hFF));
    chk_flags();
    step(1'b0, 1'b1);
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    chk_flags();
    chk("clr_valid_kept", 32'(data_valid_a), 32'(1));
    rdy_mode = 1;
    step(1'b0);
    step(1'b0);
    chk("ovr_drained", 32'(data_valid_a), 32'(0));

    // Accept of the old word coincides with delivery of the next.
    rdy_mode = 0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1);
    chk("simul_valid", 32'(data_valid_a), 32'(1));
    chk("simul_data", 32'(data_out_a), 32'(8'h22));
    chk_flags();
    rdy_mode = 1;
    step(1'b0);
    step(1'b0);
    chk("simul_drained", 32'(data_valid_a), 32'(0));

    send_frame(8'h01, 1'b0, 1'b1);
    chk_flags();
    step(1'b0);
    chk("ferr_no_valid", 32'(data_valid_a), 32'(0));
    step(1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    step(1'b0);
    chk_flags();
    send_frame(8'h42, 1'b0, 1'b1, 1'b1);
    chk_flags();
    step(1'b0, 1'b1);
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    chk_flags();

    step(1'b1);
    for (int i = 0; i < 4; i++) step(i[0]);
    do_reset();
    repeat (4) step(1'b0);
    chk("post_rst_valid", 32'(data_valid_a), 32'(0));
    send_frame(8'h5A, 1'b1, 1'b0);
    step(1'b0);
    step(1'b0);
    chk_flags();

    do_reset();
    step(1'b0);
    repeat (17) step(1'b1);
    chk("wrap_cnt4", 32'(cnt_b), 32'(1));
    chk("wrap_cnt16", 32'(cnt_a), 32'(17));
    do_reset();
    repeat (3) step(1'b0);

    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      n = 0;
      while (data_valid_a && n < 200) begin
        step(1'b0);
        n++;
      end
      if (data_valid_a) chk("drain_timeout", 32'(data_valid_a), 32'(0));
      w = W'($urandom);
      e = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 3) == 0);
      send_frame(w, !e, e, c);
      chk_flags();
      repeat ($urandom_range(0, 3)) step(1'b0);
    end
    rdy_mode = 1;
    repeat (5) step(1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    chk_flags();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
